// File: rtl/int_arbiter.sv
// Bus-request interrupt arbiter: picks the highest-level eligible device,
// presents its vector to the CPU until acknowledged or withdrawn, then
// returns a one-cycle acknowledge to that device.
module int_arbiter #(
    parameter int                  NDEV       = 4,
    parameter logic [3*NDEV-1:0]   DEV_LEVELS = 12'b101_100_100_110
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NDEV-1:0]     dev_req,
    input  logic [8*NDEV-1:0]   dev_vectors,
    input  logic [2:0]          cpu_ipl,
    input  logic                interrupt_ack,
    output logic                interrupt,
    output logic [7:0]          vector,
    output logic [NDEV-1:0]     dev_ack,
    output logic [2:0]          grant_level
);

    localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        ACK     = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   grant_idx_reg;

    logic [2:0]      dev_level [NDEV];
    logic [7:0]      dev_vec   [NDEV];
    logic [NDEV-1:0] eligible;

    logic [IW-1:0]   win_idx;
    logic [2:0]      win_level;
    logic            win_any;

    // Per-device level/vector unpacking and eligibility against CPU priority.
    // Level 0 can never exceed cpu_ipl, so it is never eligible.
    genvar gi;
    generate
        for (gi = 0; gi < NDEV; gi++) begin : g_dev
            assign dev_level[gi] = DEV_LEVELS[3*gi +: 3];
            assign dev_vec[gi]   = dev_vectors[8*gi +: 8];
            assign eligible[gi]  = dev_req[gi] && (dev_level[gi] > cpu_ipl);
        end
    endgenerate

    // Winner search: scan from the top index down with >= so that on a level
    // tie the lowest index is the last to overwrite and therefore wins.
    always_comb begin
        win_idx   = '0;
        win_level = '0;
        win_any   = 1'b0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (eligible[i] && (!win_any || dev_level[i] >= win_level)) begin
                win_idx   = IW'(i);
                win_level = dev_level[i];
                win_any   = 1'b1;
            end
        end
    end

    // Grant sequencer with registered outputs; the grant is frozen from the
    // moment it is taken until ack or passive release (no preemption).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            grant_idx_reg <= '0;
            interrupt     <= 1'b0;
            vector        <= '0;
            dev_ack       <= '0;
            grant_level   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    dev_ack <= '0;
                    if (win_any) begin
                        state_reg     <= GRANT;
                        grant_idx_reg <= win_idx;
                        interrupt     <= 1'b1;
                        vector        <= dev_vec[win_idx];
                        grant_level   <= win_level;
                    end
                end
                GRANT: begin
                    // Ack takes priority over a simultaneous withdrawal.
                    if (interrupt_ack) begin
                        state_reg              <= ACK;
                        interrupt              <= 1'b0;
                        dev_ack                <= '0;
                        dev_ack[grant_idx_reg] <= 1'b1;
                    end else if (!eligible[grant_idx_reg]) begin
                        state_reg   <= IDLE;
                        interrupt   <= 1'b0;
                        vector      <= '0;
                        grant_level <= '0;
                    end
                end
                ACK: begin
                    state_reg   <= RECOVER;
                    dev_ack     <= '0;
                    vector      <= '0;
                    grant_level <= '0;
                end
                RECOVER: begin
                    // Idle cycle lets the acknowledged device drop its request.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg   <= IDLE;
                    interrupt   <= 1'b0;
                    vector      <= '0;
                    dev_ack     <= '0;
                    grant_level <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_arbiter.sv
// Scenario bench for int_arbiter: each task walks a per-cycle table of
// stimulus and expected outputs through a scoreboard queue.
module tb_int_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  dev_req;
    logic [31:0] dev_vectors;
    logic [2:0]  cpu_ipl;
    logic        interrupt_ack;
    logic        interrupt;
    logic [7:0]  vector;
    logic [3:0]  dev_ack;
    logic [2:0]  grant_level;

    // dev3..dev0 vectors: 070, 064, 060, 100 (octal)
    localparam logic [31:0] VNORM = {8'o070, 8'o064, 8'o060, 8'o100};
    localparam logic [31:0] VALT  = 32'hA5C3_9F11;

    int passed = 0;
    int total  = 0;
    logic [15:0] exp_q[$];

    int_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .dev_req       (dev_req),
        .dev_vectors   (dev_vectors),
        .cpu_ipl       (cpu_ipl),
        .interrupt_ack (interrupt_ack),
        .interrupt     (interrupt),
        .vector        (vector),
        .dev_ack       (dev_ack),
        .grant_level   (grant_level)
    );

    always #5 clk = ~clk;

    // Stimulus word: {alt_vectors, reset, ack, ipl[2:0], req[3:0]}
    function automatic logic [9:0] S(input logic alt, input logic rst, input logic ak,
                                     input logic [2:0] ipl, input logic [3:0] req);
        return {alt, rst, ak, ipl, req};
    endfunction

    // Expected word: {interrupt, vector[7:0], dev_ack[3:0], grant_level[2:0]}
    function automatic logic [15:0] E(input logic intr, input logic [7:0] v,
                                      input logic [3:0] da, input logic [2:0] lv);
        return {intr, v, da, lv};
    endfunction

    task automatic apply(input logic [9:0] s);
        dev_vectors   = s[9] ? VALT : VNORM;
        reset         = s[8];
        interrupt_ack = s[7];
        cpu_ipl       = s[6:4];
        dev_req       = s[3:0];
    endtask

    task automatic test_reset;
        logic [9:0]  st [3];
        logic [15:0] ex [3];
        logic [15:0] got, e;
        st = '{S(0,1,0,0,4'b0000), S(0,1,1,0,4'b1111), S(0,0,0,0,4'b0000)};
        ex = '{E(0,0,0,0), E(0,0,0,0), E(0,0,0,0)};
        for (int k = 0; k < 3; k++) begin
            apply(st[k]); exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = {interrupt, vector, dev_ack, grant_level}; total++;
            if (got !== e) $display("FAIL reset step %0d: got %h expected %h", k, got, e);
            else begin passed++; $display("reset step %0d ok %h", k, got); end
        end
    endtask

    task automatic test_single;
        logic [9:0]  st [5];
        logic [15:0] ex [5];
        logic [15:0] got, e;
        st = '{S(0,0,0,0,4'b0001), S(0,0,0,0,4'b0001), S(0,0,1,0,4'b0001),
               S(0,0,0,0,4'b0000), S(0,0,0,0,4'b0000)};
        ex = '{E(1,8'o100,4'b0000,6), E(1,8'o100,4'b0000,6), E(0,8'o100,4'b0001,6),
               E(0,0,0,0), E(0,0,0,0)};
        for (int k = 0; k < 5; k++) begin
            apply(st[k]); exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = {interrupt, vector, dev_ack, grant_level}; total++;
            if (got !== e) $display("FAIL single step %0d: got %h expected %h", k, got, e);
            else begin passed++; $display("single step %0d ok %h", k, got); end
        end
    endtask

    task automatic test_tie;
        logic [9:0]  st [8];
        logic [15:0] ex [8];
        logic [15:0] got, e;
        st = '{S(0,0,0,0,4'b0110), S(0,0,1,0,4'b0110), S(0,0,0,0,4'b0100),
               S(0,0,0,0,4'b0100), S(0,0,0,0,4'b0100), S(0,0,1,0,4'b0100),
               S(0,0,0,0,4'b0000), S(0,0,0,0,4'b0000)};
        ex = '{E(1,8'o060,4'b0000,4), E(0,8'o060,4'b0010,4), E(0,0,0,0),
               E(0,0,0,0), E(1,8'o064,4'b0000,4), E(0,8'o064,4'b0100,4),
               E(0,0,0,0), E(0,0,0,0)};
        for (int k = 0; k < 8; k++) begin
            apply(st[k]); exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = {interrupt, vector, dev_ack, grant_level}; total++;
            if (got !== e) $display("FAIL tie step %0d: got %h expected %h", k, got, e);
            else begin passed++; $display("tie step %0d ok %h", k, got); end
        end
    endtask

    task automatic test_ipl;
        logic [9:0]  st [11];
        logic [15:0] ex [11];
        logic [15:0] got, e;
        st = '{S(0,0,0,4,4'b1010), S(0,0,1,4,4'b1010), S(0,0,0,4,4'b0000),
               S(0,0,0,5,4'b1010), S(0,0,0,5,4'b1010), S(0,0,0,5,4'b1010),
               S(0,0,0,6,4'b0001), S(0,0,0,5,4'b0001), S(0,0,1,5,4'b0001),
               S(0,0,0,0,4'b0000), S(0,0,0,0,4'b0000)};
        ex = '{E(1,8'o070,4'b0000,5), E(0,8'o070,4'b1000,5), E(0,0,0,0),
               E(0,0,0,0), E(0,0,0,0), E(0,0,0,0),
               E(0,0,0,0), E(1,8'o100,4'b0000,6), E(0,8'o100,4'b0001,6),
               E(0,0,0,0), E(0,0,0,0)};
        for (int k = 0; k < 11; k++) begin
            apply(st[k]); exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = {interrupt, vector, dev_ack, grant_level}; total++;
            if (got !== e) $display("FAIL ipl step %0d: got %h expected %h", k, got, e);
            else begin passed++; $display("ipl step %0d ok %h", k, got); end
        end
    endtask

    task automatic test_no_preempt;
        logic [9:0]  st [10];
        logic [15:0] ex [10];
        logic [15:0] got, e;
        st = '{S(0,0,0,0,4'b0010), S(1,0,0,0,4'b0011), S(1,0,0,0,4'b0011),
               S(0,0,1,0,4'b0011), S(0,0,0,0,4'b0001), S(0,0,0,0,4'b0001),
               S(0,0,0,0,4'b0001), S(0,0,1,0,4'b0001), S(0,0,1,0,4'b0000),
               S(0,0,1,0,4'b0000)};
        ex = '{E(1,8'o060,4'b0000,4), E(1,8'o060,4'b0000,4), E(1,8'o060,4'b0000,4),
               E(0,8'o060,4'b0010,4), E(0,0,0,0), E(0,0,0,0),
               E(1,8'o100,4'b0000,6), E(0,8'o100,4'b0001,6), E(0,0,0,0),
               E(0,0,0,0)};
        for (int k = 0; k < 10; k++) begin
            apply(st[k]); exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = {interrupt, vector, dev_ack, grant_level}; total++;
            if (got !== e) $display("FAIL no_preempt step %0d: got %h expected %h", k, got, e);
            else begin passed++; $display("no_preempt step %0d ok %h", k, got); end
        end
    endtask

    task automatic test_release;
        logic [9:0]  st [6];
        logic [15:0] ex [6];
        logic [15:0] got, e;
        st = '{S(0,0,0,0,4'b0010), S(0,0,0,6,4'b0010), S(0,0,0,6,4'b0010),
               S(0,0,0,0,4'b0010), S(0,0,0,0,4'b0000), S(0,0,0,0,4'b0000)};
        ex = '{E(1,8'o060,4'b0000,4), E(0,0,0,0), E(0,0,0,0),
               E(1,8'o060,4'b0000,4), E(0,0,0,0), E(0,0,0,0)};
        for (int k = 0; k < 6; k++) begin
            apply(st[k]); exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = {interrupt, vector, dev_ack, grant_level}; total++;
            if (got !== e) $display("FAIL release step %0d: got %h expected %h", k, got, e);
            else begin passed++; $display("release step %0d ok %h", k, got); end
        end
    endtask

    task automatic test_ack_vs_release;
        logic [9:0]  st [4];
        logic [15:0] ex [4];
        logic [15:0] got, e;
        st = '{S(0,0,0,0,4'b0100), S(0,0,1,0,4'b0000), S(0,0,0,0,4'b0000),
               S(0,0,0,0,4'b0000)};
        ex = '{E(1,8'o064,4'b0000,4), E(0,8'o064,4'b0100,4), E(0,0,0,0), E(0,0,0,0)};
        for (int k = 0; k < 4; k++) begin
            apply(st[k]); exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = {interrupt, vector, dev_ack, grant_level}; total++;
            if (got !== e) $display("FAIL ack_vs_release step %0d: got %h expected %h", k, got, e);
            else begin passed++; $display("ack_vs_release step %0d ok %h", k, got); end
        end
    endtask

    task automatic test_reset_mid_grant;
        logic [9:0]  st [7];
        logic [15:0] ex [7];
        logic [15:0] got, e;
        st = '{S(0,0,0,0,4'b0001), S(0,1,1,0,4'b0001), S(0,0,0,0,4'b0000),
               S(0,0,0,0,4'b0001), S(0,0,1,0,4'b0000), S(0,0,0,0,4'b0000),
               S(0,0,0,0,4'b0000)};
        ex = '{E(1,8'o100,4'b0000,6), E(0,0,0,0), E(0,0,0,0),
               E(1,8'o100,4'b0000,6), E(0,8'o100,4'b0001,6), E(0,0,0,0),
               E(0,0,0,0)};
        for (int k = 0; k < 7; k++) begin
            apply(st[k]); exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = {interrupt, vector, dev_ack, grant_level}; total++;
            if (got !== e) $display("FAIL reset_mid step %0d: got %h expected %h", k, got, e);
            else begin passed++; $display("reset_mid step %0d ok %h", k, got); end
        end
    endtask

    initial begin
        apply(S(0,1,0,0,4'b0000));
        test_reset();
        test_single();
        test_tie();
        test_ipl();
        test_no_preempt();
        test_release();
        test_ack_vs_release();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
